// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame parameters.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_t;

    localparam int DEF_NB_DATA    = 8;
    localparam int DEF_SB_TICK    = 16;
    localparam int DEF_OVERSAMPLE = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: detects a start edge, samples each bit at its centre,
// and reports the received word with a one-cycle done pulse and a stop-bit error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int TICK_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE/2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  IDX_LAST  = BIT_W'(NB_DATA - 1);

    logic               rx_s;
    uart_state_t        state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [NB_DATA-1:0] shreg;

    // Idle-high line: reset the synchronizer to 1 so reset release never looks like a start edge.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            // Line back high at mid-start means it was only a glitch.
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[NB_DATA-1:1]};
                            if (bit_idx == IDX_LAST)
                                state <= STOP;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            state       <= IDLE;
                            o_data      <= shreg;
                            o_frame_err <= ~rx_s;
                            o_rx_done   <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized frames against a queue-based model of the expected received words.
module tb_uart_rx;

    localparam int TICK_DIV = 4;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic       i_tick = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    logic       tick_en = 1'b1;
    logic [7:0] div = '0;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done = 0;
    int         n_exp = 0;
    logic [8:0] exp_q[$];
    logic [7:0] last_data;
    logic       last_err;

    uart_rx #(.NB_DATA(8), .SB_TICK(16), .OVERSAMPLE(16)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .i_tick      (i_tick),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    always #10 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        div    <= (div == TICK_DIV-1) ? 8'd0 : div + 8'd1;
        i_tick <= tick_en && (div == TICK_DIV-1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns just after the edge on which the DUT consumed the n-th tick.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            while (!i_tick) @(posedge i_clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int freeze_bit);
        exp_q.push_back({~stop_ok, d});
        n_exp++;
        last_data = d;
        last_err  = ~stop_ok;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            if (i == freeze_bit) begin
                wait_ticks(5);
                tick_en = 1'b0;
                repeat (100) @(posedge i_clk);
                #1 tick_en = 1'b1;
                wait_ticks(11);
            end else begin
                wait_ticks(16);
            end
        end
        if (stop_ok) begin
            i_rx = 1'b1;
            wait_ticks(16);
        end else begin
            // Release early so the low tail is rejected as a glitch rather than a start.
            i_rx = 1'b0;
            wait_ticks(12);
            i_rx = 1'b1;
            wait_ticks(20);
        end
    endtask

    task automatic glitch(input int len);
        i_rx = 1'b0;
        wait_ticks(len);
        i_rx = 1'b1;
        wait_ticks(30);
        chk("glitch_data_hold", o_data, last_data);
        chk("glitch_err_hold", o_frame_err, last_err);
        chk("glitch_no_done", n_done, n_exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding frame.
    initial begin
        logic [8:0] e;
        logic       prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_rx_done) begin
                n_done++;
                chk("done_gap", prev_done, 1'b0);
                chk("done_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_data", o_data, e[7:0]);
                    chk("rx_frame_err", o_frame_err, e[8]);
                end
            end
            prev_done = o_rx_done;
        end
    end

    initial begin
        logic [7:0] d;
        bit         ok;
        i_reset   = 1'b1;
        i_rx      = 1'b1;
        last_data = 8'h00;
        last_err  = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_data", o_data, 8'h00);
        chk("reset_done", o_rx_done, 1'b0);
        chk("reset_err", o_frame_err, 1'b0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, -1);
        wait_ticks(5);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        wait_ticks(10);
        chk("b2b_done_count", n_done, 4);
        glitch(3);

        send_frame(8'h55, 1'b0, -1);
        chk("err_hold", o_frame_err, 1'b1);
        chk("err_data_hold", o_data, 8'h55);

        // 0x81 aborted by reset in the middle of data bit 4.
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            i_rx = (i == 0);
            wait_ticks(16);
        end
        i_rx = 1'b0;
        wait_ticks(8);
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("midreset_data", o_data, 8'h00);
        chk("midreset_done", o_rx_done, 1'b0);
        chk("midreset_err", o_frame_err, 1'b0);
        i_rx = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        last_data = 8'h00;
        last_err  = 1'b0;
        wait_ticks(40);
        chk("post_reset_data", o_data, 8'h00);
        chk("post_reset_no_done", n_done, n_exp);
        send_frame(8'h42, 1'b1, -1);
        wait_ticks(5);

        send_frame(8'h96, 1'b1, 3);
        wait_ticks(5);

        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, -1);
            if (ok) wait_ticks($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 5));
        end

        wait_ticks(40);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_done_count", n_done, n_exp);
        chk("final_data_hold", o_data, last_data);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
